prpg_bist_ctrl: RTL and testbench

PRPG_BIST_CTRL -- requirements
Module: prpg_bist_ctrl

---
 rtl/prpg_pkg.sv | 19 +
 rtl/prpg_misr.sv | 42 ++++
 rtl/prpg_bist_ctrl.sv | 121 ++++++++++++
 tb/tb_prpg_bist_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prpg_pkg.sv
// rtl/prpg_pkg.sv - shared types and default constants for the PRPG BIST controller
//
// Purpose : FSM state enumeration plus default width, seed and MISR taps.
// Ports   : none (package).
package prpg_pkg;

  localparam int         DEF_WIDTH     = 3;
  localparam logic [2:0] DEF_SEED      = 3'b001;
  localparam logic [2:0] DEF_MISR_TAPS = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/prpg_misr.sv
// rtl/prpg_misr.sv - multiple-input signature register compacting CUT responses
//
// Purpose : q <= (q<<1) ^ (q[MSB] ? TAPS : 0) ^ d when en; synchronous clear.
// Ports   : clk   - clock
//           set_n - asynchronous active-low reset (q -> 0)
//           clr   - synchronous clear, wins over en
//           en    - capture enable
//           d     - response word folded in on capture
//           q     - current signature
module prpg_misr #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b101
) (
  input  logic             clk,
  input  logic             set_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // The shift is done in WIDTH bits, so the MSB falls off naturally.
  always_comb begin
    w_next = (r_q << 1) ^ (r_q[WIDTH-1] ? TAPS : '0) ^ d;
  end

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/prpg_bist_ctrl.sv
// rtl/prpg_bist_ctrl.sv - BIST run controller: PRPG load/advance, MISR compaction, signature compare
//
// Purpose : On start, loads the PRPG, runs NUM_PAT patterns while compacting the
//           CUT response into a MISR, compares against golden and pulses done.
// Ports   : clk, set_n (async active-low reset)
//           start, abort         - run control
//           resp [WIDTH]         - CUT response, captured every RUN cycle
//           golden [WIDTH]       - expected signature, sampled in COMPARE
//           prpg_load, prpg_seed - PRPG load strobe and constant seed
//           prpg_en              - PRPG advance enable
//           busy, done, pass     - status
//           signature [WIDTH]    - MISR contents
module prpg_bist_ctrl
  import prpg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               NUM_PAT   = 7,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] MISR_TAPS = WIDTH'(DEF_MISR_TAPS)
) (
  input  logic             clk,
  input  logic             set_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] resp,
  input  logic [WIDTH-1:0] golden,
  output logic             prpg_load,
  output logic [WIDTH-1:0] prpg_seed,
  output logic             prpg_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  // Counter holds 0..NUM_PAT; it reaches NUM_PAT on the last capture and is
  // cleared in LOAD, so it never wraps within a run.
  localparam int            CW   = $clog2(NUM_PAT + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PAT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_pass;
  logic             w_busy;
  logic             w_misr_clr;
  logic             w_misr_en;
  logic [WIDTH-1:0] w_sig;

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Abort is checked first in every busy state so it overrides all exits.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (start && !abort) w_next_state = ST_LOAD;
      ST_LOAD:    w_next_state = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)              w_next_state = ST_IDLE;
        else if (r_cnt == LAST) w_next_state = ST_COMPARE;
      end
      ST_COMPARE: w_next_state = abort ? ST_IDLE : ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  assign w_busy     = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_COMPARE);
  assign w_misr_clr = (r_state == ST_LOAD);
  // The aborting edge performs no capture: the run is simply dropped.
  assign w_misr_en  = (r_state == ST_RUN) && !abort;

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_cnt <= '0;
    end else if (w_misr_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      r_pass <= 1'b0;
    end else if (w_busy && abort) begin
      r_pass <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_pass <= 1'b0;
    end else if (r_state == ST_COMPARE) begin
      r_pass <= (w_sig == golden);
    end
  end

  prpg_misr #(
    .WIDTH (WIDTH),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .clk   (clk),
    .set_n (set_n),
    .clr   (w_misr_clr),
    .en    (w_misr_en),
    .d     (resp),
    .q     (w_sig)
  );

  assign prpg_load = (r_state == ST_LOAD);
  assign prpg_seed = SEED;
  assign prpg_en   = (r_state == ST_RUN);
  assign busy      = w_busy;
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign signature = w_sig;

endmodule

// File: tb/tb_prpg_bist_ctrl.sv
// tb/tb_prpg_bist_ctrl.sv - self-checking bench for prpg_bist_ctrl (NUM_PAT=4 and NUM_PAT=7 instances)
module tb_prpg_bist_ctrl;

  logic       clk = 1'b0;
  logic       set_n;
  logic       start;
  logic       abort;
  logic [2:0] resp;
  logic [2:0] golden;

  logic [1:0] load_o;
  logic [1:0] en_o;
  logic [1:0] busy_o;
  logic [1:0] done_o;
  logic [1:0] pass_o;
  logic [2:0] seed_o [2];
  logic [2:0] sig_o  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prpg_bist_ctrl #(.NUM_PAT(4)) u4 (
    .clk(clk), .set_n(set_n), .start(start), .abort(abort), .resp(resp), .golden(golden),
    .prpg_load(load_o[0]), .prpg_seed(seed_o[0]), .prpg_en(en_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0])
  );

  prpg_bist_ctrl u7 (
    .clk(clk), .set_n(set_n), .start(start), .abort(abort), .resp(resp), .golden(golden),
    .prpg_load(load_o[1]), .prpg_seed(seed_o[1]), .prpg_en(en_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1])
  );

  task automatic chk(input string name, input int inst, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, got, want, $time);
    end
  endtask

  // Run-timeline model: a run is described by the number of edges since start
  // was accepted. Offset 1 = load cycle, 2..N+1 = pattern cycles, N+2 = compare,
  // N+3 = done cycle, after which the run is over.
  int         np [2] = '{4, 7};
  bit         m_active [2];
  int         m_off [2];
  logic [2:0] m_sig [2];
  bit         m_pass [2];
  int         en_cnt [2];
  int         done_cnt [2];

  function automatic logic [2:0] misr_step(input logic [2:0] s, input logic [2:0] r);
    int v;
    v = (int'(s) * 2) % 8;
    if (s >= 3'd4) v = v ^ 5;
    v = v ^ int'(r);
    return v[2:0];
  endfunction

  always @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0;
        m_off[i]    = 0;
        m_sig[i]    = 3'd0;
        m_pass[i]   = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int o;
        o = m_off[i];
        if (!m_active[i]) begin
          if (start && !abort) begin
            m_active[i] = 1'b1;
            m_off[i]    = 1;
          end
        end else if (abort && o <= np[i] + 2) begin
          m_active[i] = 1'b0;
          m_pass[i]   = 1'b0;
        end else begin
          if (o == 1) begin
            m_sig[i]  = 3'd0;
            m_pass[i] = 1'b0;
          end else if (o <= np[i] + 1) begin
            m_sig[i] = misr_step(m_sig[i], resp);
          end else if (o == np[i] + 2) begin
            m_pass[i] = (m_sig[i] == golden);
          end
          if (o == np[i] + 3) m_active[i] = 1'b0;
          else                m_off[i]    = o + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (set_n) begin
      for (int i = 0; i < 2; i++) begin
        int  o;
        bit  a;
        o = m_off[i];
        a = m_active[i];
        chk("prpg_load", i, int'(load_o[i]), int'(a && o == 1));
        chk("prpg_en",   i, int'(en_o[i]),   int'(a && o >= 2 && o <= np[i] + 1));
        chk("busy",      i, int'(busy_o[i]), int'(a && o >= 1 && o <= np[i] + 2));
        chk("done",      i, int'(done_o[i]), int'(a && o == np[i] + 3));
        chk("pass",      i, int'(pass_o[i]), int'(m_pass[i]));
        chk("signature", i, int'(sig_o[i]),  int'(m_sig[i]));
        chk("prpg_seed", i, int'(seed_o[i]), 1);
        if (en_o[i])   en_cnt[i]++;
        if (done_o[i]) done_cnt[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_load"}, i, int'(load_o[i]), 0);
      chk({name, "_en"},   i, int'(en_o[i]),   0);
      chk({name, "_busy"}, i, int'(busy_o[i]), 0);
      chk({name, "_done"}, i, int'(done_o[i]), 0);
      chk({name, "_pass"}, i, int'(pass_o[i]), 0);
      chk({name, "_sig"},  i, int'(sig_o[i]),  0);
      chk({name, "_seed"}, i, int'(seed_o[i]), 1);
    end
  endtask

  initial begin
    int d0;
    int d1;
    set_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    resp   = 3'b001;
    golden = 3'b010;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    #3 set_n = 1'b1;

    // Basic run, resp=001, golden=010: NUM_PAT=4 -> 010 pass, NUM_PAT=7 -> 000 fail.
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("lit_load_after_k", 0, int'(load_o[0]), 1);
    chk("lit_load_after_k", 1, int'(load_o[1]), 1);
    tick(5);
    chk("lit_done_k5", 0, int'(done_o[0]), 0);
    tick(1);
    chk("lit_done_k6", 0, int'(done_o[0]), 1);
    chk("lit_sig4", 0, int'(sig_o[0]), 3'b010);
    chk("lit_pass4", 0, int'(pass_o[0]), 1);
    tick(3);
    chk("lit_done_k9", 1, int'(done_o[1]), 1);
    chk("lit_sig7", 1, int'(sig_o[1]), 3'b000);
    chk("lit_pass7", 1, int'(pass_o[1]), 0);
    chk("lit_pass4_hold", 0, int'(pass_o[0]), 1);
    chk("lit_sig4_hold", 0, int'(sig_o[0]), 3'b010);
    tick(2);
    chk("lit_en_cycles", 0, en_cnt[0], 4);
    chk("lit_en_cycles", 1, en_cnt[1], 7);
    chk("lit_done_once", 0, done_cnt[0], 1);
    chk("lit_done_once", 1, done_cnt[1], 1);

    // start together with abort in IDLE does nothing.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("lit_start_abort_idle", 0, int'(busy_o[0]), 0);
    chk("lit_start_abort_idle", 1, int'(busy_o[1]), 0);
    tick(1);

    // Abort on the third pattern cycle.
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lit_abort_busy", i, int'(busy_o[i]), 0);
      chk("lit_abort_en",   i, int'(en_o[i]),   0);
      chk("lit_abort_pass", i, int'(pass_o[i]), 0);
    end
    tick(12);
    chk("lit_abort_no_done", 0, done_cnt[0] - d0, 0);
    chk("lit_abort_no_done", 1, done_cnt[1] - d1, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("lit_after_abort_done", 0, done_cnt[0] - d0, 1);
    chk("lit_after_abort_done", 1, done_cnt[1] - d1, 1);
    chk("lit_after_abort_sig4", 0, int'(sig_o[0]), 3'b010);
    chk("lit_after_abort_pass4", 0, int'(pass_o[0]), 1);

    // start held high for 24 edges with a changing response.
    golden = 3'b000;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      resp = 3'((c * 3 + 1) % 8);
      tick(1);
    end
    start = 1'b0;
    resp  = 3'b001;
    tick(14);
    chk("lit_held_start_runs", 0, done_cnt[0] - d0, 3);
    chk("lit_held_start_runs", 1, done_cnt[1] - d1, 3);

    // golden=000 with constant resp=001: the 7-pattern run now passes.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("lit_pass7_match", 1, int'(pass_o[1]), 1);
    chk("lit_pass4_nomatch", 0, int'(pass_o[0]), 0);

    // Asynchronous reset in the middle of a run.
    golden = 3'b010;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    #2 set_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    #3 set_n = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("lit_post_reset_sig4", 0, int'(sig_o[0]), 3'b010);
    chk("lit_post_reset_pass4", 0, int'(pass_o[0]), 1);
    chk("lit_post_reset_sig7", 1, int'(sig_o[1]), 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
